// File: rtl/derandomizer_byte.sv
`default_nettype none
//=============================================================================
// Module   : derandomizer_byte
// Purpose  : Receive-side PRBS derandomizer (1 + x^14 + x^15) for the WiMAX
//            OFDM PHY. Removes the transmit keystream 8 bits per clock. The
//            LFSR is reseeded from rand_iv at the start of each burst, bytes
//            are counted against burst_len, and the final byte is flagged.
// Ports    : clk        - clock, all logic on posedge
//            reset      - asynchronous active-low reset
//            rand_iv    - LFSR seed, sampled on the first byte of a burst
//            burst_len  - burst length in bytes, sampled with rand_iv
//            in_start   - marks in_data as the first byte of a burst
//            in_data    - randomized byte (bit 7 first in time)
//            in_valid   - in_data valid
//            in_ready   - block accepts in_data this cycle
//            out_data   - derandomized byte (bit 7 first in time)
//            out_valid  - out_data valid
//            out_ready  - downstream accepts out_data
//            out_last   - out_data is the final byte of the burst
//            err        - one-cycle protocol error pulse
// Revision : 1.0 - initial release
//=============================================================================
module derandomizer_byte #(
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [14:0]      rand_iv,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             in_start,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             err
);

   localparam logic [LEN_W-1:0] c_len_zero = '0;
   localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [14:0]      lfsr_q, lfsr_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             err_q, err_d;

   logic             in_xfer;
   logic             new_burst;
   logic [14:0]      seed;
   logic [14:0]      lfsr_nxt;
   logic [7:0]       dec_byte;

   // Single output register: a new byte may enter whenever the register is
   // empty or is being drained in this same cycle.
   assign in_ready  = !out_valid_q || out_ready;
   assign in_xfer   = in_valid && in_ready;

   // Any byte accepted in IDLE opens a burst; in RUN only in_start does.
   assign new_burst = (state_q == ST_IDLE) || in_start;
   assign seed      = new_burst ? rand_iv : lfsr_q;

   // Eight LFSR steps unrolled; the first step pairs with in_data[7].
   always_comb begin
      logic [14:0] v;
      logic        fb;
      v        = seed;
      fb       = 1'b0;
      dec_byte = '0;
      for (int i = 7; i >= 0; i--) begin
         fb          = v[13] ^ v[14];
         dec_byte[i] = in_data[i] ^ fb;
         v           = {v[13:0], fb};
      end
      lfsr_nxt = v;
   end

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      err_d       = 1'b0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (in_xfer) begin
         if (new_burst) begin
            // A start marker inside a running burst truncates that burst.
            if (state_q == ST_RUN) begin
               err_d = 1'b1;
            end
            if (burst_len == c_len_zero) begin
               // Zero-length burst: swallow the byte and flag it.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
               out_data_d  = dec_byte;
               lfsr_d      = lfsr_nxt;
               count_d     = burst_len - c_len_one;
               out_last_d  = (burst_len == c_len_one);
               state_d     = (burst_len == c_len_one) ? ST_IDLE : ST_RUN;
            end
         end else begin
            // count_q holds the bytes still owed, so 1 means this is the last.
            out_valid_d = 1'b1;
            out_data_d  = dec_byte;
            lfsr_d      = lfsr_nxt;
            count_d     = count_q - c_len_one;
            out_last_d  = (count_q == c_len_one);
            state_d     = (count_q == c_len_one) ? ST_IDLE : ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign err       = err_q;

endmodule
`default_nettype wire
